period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Receive-side counterpart to the divider chain: measures a divided or toggled clock rather than generating one.
- Samples an asynchronous input `sig_in`, such as a T flip-flop `q` output, in the `clk` domain.
- Reports the period and high time of `sig_in` in `clk` cycles, with a one-cycle `valid` strobe per completed period.
- Used for self-check of divider stages and for frequency readback.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in` (allowed 2..4).

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous reset, active-low (sampled on rising `clk`; 0 = reset).
- en  input  1  measurement enable; low forces re-acquisition.
- sig_in  input  1  asynchronous signal under measurement.
- period  output  CNT_W  last measured rising-to-rising distance, in `clk` cycles.
- high_time  output  CNT_W  cycles `sig_in` was high within that period.
- valid  output  1  one-cycle strobe when `period`/`high_time` update.
- timeout  output  1  one-cycle strobe when no rising edge arrives within 2^CNT_W-1 cycles.
- no_sig  output  1  level; high while no measurement is in progress (ACQ state).

Behaviour:
- Reset (`rst`=0 at a `clk` edge):
  - Synchronizer flops, edge-detect flop, `cnt`, `hcnt`, `period`, `high_time` go to 0.
  - `valid` and `timeout` go to 0; `no_sig` goes to 1; state goes to ACQ.
  - Reset mid-measurement discards the partial count with no strobe.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops to give `s`. A delayed copy `s_d` feeds edge detection.
  - `rise` = `s` & ~`s_d`.
  - `s` is the only signal used internally.
- State ACQ:
  - `cnt` and `hcnt` are held at 0; `no_sig`=1.
  - On `rise` with `en`=1: go to MEAS, `cnt`<=1, `hcnt`<=1, `no_sig`<=0.
  - No `valid` is issued for this first edge. This arms the block only, so a spurious post-reset edge caused by the synchronizer clearing to 0 never produces a result.
- State MEAS, evaluated each cycle in this priority:
  1. `en`=0: go to ACQ, clear counters, no strobes.
  2. `rise`:
     - `period`<=`cnt`, `high_time`<=`hcnt`, `valid`<=1.
     - `cnt`<=1, `hcnt`<=1, stay in MEAS.
  3. `cnt` = 2^CNT_W-1:
     - `timeout`<=1, go to ACQ, `no_sig`<=1.
     - `period` and `high_time` keep their old values; no `valid`.
  4. Otherwise:
     - `cnt`<=`cnt`+1.
     - `hcnt`<=`hcnt`+1 if `s`=1, else hold.
- Counter rules:
  - `cnt` never wraps; saturation triggers the timeout instead.
  - `hcnt` ≤ `cnt` always, so it cannot overflow.
  - For a clean synchronized waveform of P cycles with H cycles high: `period`=P, `high_time`=H.
- Strobes and outputs:
  - `valid` and `timeout` are registered and high for exactly one cycle. They are never high together.
  - `period` and `high_time` change only in the same cycle `valid` rises, and hold otherwise.
- Latency: an `sig_in` rising edge seen at `clk` edge k produces `valid`=1 in the cycle after edge k+SYNC_STAGES.
- Boundary cases:
  - Constant 0 or constant 1 input: one `timeout` per 2^CNT_W-1 cycles after arming; then stays in ACQ until the next rise.
  - Minimum measurable period is 2 cycles (alternating input): `period`=2, `high_time`=1.
  - `en` deassert/reassert mid-period: that period is discarded; the first edge after re-enable only arms.
  - `rise` and saturation in the same cycle: `rise` wins, so `period`=2^CNT_W-1 with `valid`.

Test Plan:
- Reset/arm: hold `rst`=0 for 3 cycles with `sig_in`=1, then release → `no_sig`=1, `period`=0. The first detected rise gives no `valid` and `no_sig` falls to 0.
- T-flip-flop divided input: `sig_in` toggles every 5 `clk` cycles → first `valid` occurs one period after arming. Thereafter every 10 cycles `period`=10 and `high_time`=5, and `valid` is high for exactly 1 cycle.
- Asymmetric duty cycle: `sig_in` high 3, low 9, repeated → `period`=12, `high_time`=3 on each `valid`.
- Timeout with CNT_W=6: arm, then hold `sig_in` low → `timeout` pulses exactly 63 cycles after the arming rise is detected. Then `no_sig`=1, `period` is unchanged, and no `valid` occurs.
- Enable and reset mid-period:
  - Drop `en` for 2 cycles mid-period → no `valid` for that period, `no_sig`=1. After `en` returns, the next rise only arms and the following rise gives a correct period.
  - Repeat the scenario using `rst`=0 instead of `en` → all outputs return to their reset values.
- Minimum period: `sig_in` alternates every cycle → `period`=2, `high_time`=1, with `valid` every 2 cycles.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an async input in clk cycles.
// Emits a one-cycle valid per completed period and a timeout on saturation.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             no_sig
);

    typedef enum logic {
        ACQ,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nx;
    logic [CNT_W-1:0] period_nx;
    logic [CNT_W-1:0] high_nx;
    logic             valid_nx;
    logic             timeout_nx;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign no_sig = (state == ACQ);

    // Synchronizer chain plus the delayed copy used for rising-edge detect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACQ;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, counters and result/strobe updates; rise beats saturation.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hcnt_nx    = hcnt;
        period_nx  = period;
        high_nx    = high_time;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        unique case (state)
            ACQ: begin
                cnt_nx  = '0;
                hcnt_nx = '0;
                if (rise && en) begin
                    state_nx = MEAS;
                    cnt_nx   = CNT_ONE;
                    hcnt_nx  = CNT_ONE;
                end
            end
            MEAS: begin
                if (!en) begin
                    state_nx = ACQ;
                    cnt_nx   = '0;
                    hcnt_nx  = '0;
                end else if (rise) begin
                    period_nx = cnt;
                    high_nx   = hcnt;
                    valid_nx  = 1'b1;
                    cnt_nx    = CNT_ONE;
                    hcnt_nx   = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    timeout_nx = 1'b1;
                    state_nx   = ACQ;
                    cnt_nx     = '0;
                    hcnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                    if (s) begin
                        hcnt_nx = hcnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_nx = ACQ;
                cnt_nx   = '0;
                hcnt_nx  = '0;
            end
        endcase
    end

    // Counters, result registers and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            hcnt      <= hcnt_nx;
            period    <= period_nx;
            high_time <= high_nx;
            valid     <= valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter with CNT_W=6.
// Each task drives one scenario and compares against hand-computed values.
module tb_period_meter;

    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         no_sig;

    int n_chk;
    int n_fail;
    int cyc;
    int arm_cyc;
    int vdbl;
    int both;
    int vq_p[$];
    int vq_h[$];
    int vq_t[$];
    int tq[$];
    logic prev_ns;
    logic prev_v;

    period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .no_sig    (no_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            vq_p.push_back(int'(period));
            vq_h.push_back(int'(high_time));
            vq_t.push_back(cyc);
        end
        if (timeout) tq.push_back(cyc);
        if (valid && timeout) both++;
        if (valid && prev_v) vdbl++;
        if (prev_ns && !no_sig) arm_cyc = cyc;
        prev_v  = valid;
        prev_ns = no_sig;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
    endtask

    task automatic clear_q();
        vq_p.delete();
        vq_h.delete();
        vq_t.delete();
        tq.delete();
        vdbl    = 0;
        both    = 0;
        arm_cyc = -1000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) step(1'b0);
        rst = 1'b1;
        repeat (3) step(1'b0);
        clear_q();
    endtask

    task automatic test_reset();
        clear_q();
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) step(1'b1);
        n_chk++;
        if (period !== 0 || high_time !== 0) begin
            n_fail++;
            $display("FAIL reset_vals: period=%0d high=%0d, want 0/0", period, high_time);
        end
        n_chk++;
        if (no_sig !== 1'b1 || valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: no_sig=%b valid=%b timeout=%b, want 1/0/0", no_sig, valid, timeout);
        end
        rst = 1'b1;
        step(1'b1);
        n_chk++;
        if (no_sig !== 1'b1 || period !== 0) begin
            n_fail++;
            $display("FAIL reset_release: no_sig=%b period=%0d, want 1/0", no_sig, period);
        end
        repeat (3) step(1'b1);
        n_chk++;
        if (no_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_arm: no_sig=%b, want 0", no_sig);
        end
        n_chk++;
        if (vq_p.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_arm_novalid: valids=%0d, want 0", vq_p.size());
        end
    endtask

    task automatic test_tff();
        do_reset();
        wave(5, 5, 6);
        repeat (4) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 5) begin
            n_fail++;
            $display("FAIL tff_count: valids=%0d, want 5", vq_p.size());
        end
        for (int i = 0; i < vq_p.size(); i++) begin
            n_chk++;
            if (vq_p[i] !== 10 || vq_h[i] !== 5) begin
                n_fail++;
                $display("FAIL tff_vals[%0d]: period=%0d high=%0d, want 10/5", i, vq_p[i], vq_h[i]);
            end
        end
        for (int i = 1; i < vq_t.size(); i++) begin
            n_chk++;
            if (vq_t[i] - vq_t[i-1] !== 10) begin
                n_fail++;
                $display("FAIL tff_spacing[%0d]: gap=%0d, want 10", i, vq_t[i] - vq_t[i-1]);
            end
        end
        if (vq_t.size() > 0) begin
            n_chk++;
            if (vq_t[0] - arm_cyc !== 10) begin
                n_fail++;
                $display("FAIL tff_first: gap=%0d, want 10", vq_t[0] - arm_cyc);
            end
        end
        n_chk++;
        if (vdbl !== 0 || both !== 0 || tq.size() !== 0) begin
            n_fail++;
            $display("FAIL tff_strobes: dbl=%0d both=%0d to=%0d, want 0/0/0", vdbl, both, tq.size());
        end
    endtask

    task automatic test_duty();
        do_reset();
        wave(3, 9, 5);
        repeat (3) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 4) begin
            n_fail++;
            $display("FAIL duty_count: valids=%0d, want 4", vq_p.size());
        end
        for (int i = 0; i < vq_p.size(); i++) begin
            n_chk++;
            if (vq_p[i] !== 12 || vq_h[i] !== 3) begin
                n_fail++;
                $display("FAIL duty_vals[%0d]: period=%0d high=%0d, want 12/3", i, vq_p[i], vq_h[i]);
            end
        end
    endtask

    task automatic test_min_period();
        do_reset();
        wave(1, 1, 10);
        repeat (3) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 9) begin
            n_fail++;
            $display("FAIL min_count: valids=%0d, want 9", vq_p.size());
        end
        for (int i = 0; i < vq_p.size(); i++) begin
            n_chk++;
            if (vq_p[i] !== 2 || vq_h[i] !== 1) begin
                n_fail++;
                $display("FAIL min_vals[%0d]: period=%0d high=%0d, want 2/1", i, vq_p[i], vq_h[i]);
            end
        end
        for (int i = 1; i < vq_t.size(); i++) begin
            n_chk++;
            if (vq_t[i] - vq_t[i-1] !== 2) begin
                n_fail++;
                $display("FAIL min_spacing[%0d]: gap=%0d, want 2", i, vq_t[i] - vq_t[i-1]);
            end
        end
        n_chk++;
        if (vdbl !== 0) begin
            n_fail++;
            $display("FAIL min_width: double-cycle valids=%0d, want 0", vdbl);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        wave(1, 62, 2);
        step(1'b1);
        repeat (4) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 2 || tq.size() !== 0) begin
            n_fail++;
            $display("FAIL sat_count: valids=%0d timeouts=%0d, want 2/0", vq_p.size(), tq.size());
        end
        for (int i = 0; i < vq_p.size(); i++) begin
            n_chk++;
            if (vq_p[i] !== 63 || vq_h[i] !== 1) begin
                n_fail++;
                $display("FAIL sat_vals[%0d]: period=%0d high=%0d, want 63/1", i, vq_p[i], vq_h[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        wave(3, 9, 1);
        repeat (3) step(1'b1);
        repeat (80) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 1 || tq.size() !== 1) begin
            n_fail++;
            $display("FAIL to_count: valids=%0d timeouts=%0d, want 1/1", vq_p.size(), tq.size());
        end
        if (vq_t.size() == 1 && tq.size() == 1) begin
            n_chk++;
            if (tq[0] - vq_t[0] !== 63) begin
                n_fail++;
                $display("FAIL to_delay: gap=%0d, want 63", tq[0] - vq_t[0]);
            end
        end
        n_chk++;
        if (no_sig !== 1'b1 || period !== 12 || high_time !== 3) begin
            n_fail++;
            $display("FAIL to_hold: no_sig=%b period=%0d high=%0d, want 1/12/3", no_sig, period, high_time);
        end
        repeat (70) step(1'b0);
        n_chk++;
        if (tq.size() !== 1 || both !== 0) begin
            n_fail++;
            $display("FAIL to_idle: timeouts=%0d both=%0d, want 1/0", tq.size(), both);
        end
        do_reset();
        repeat (71) step(1'b1);
        n_chk++;
        if (tq.size() !== 1 || vq_p.size() !== 0) begin
            n_fail++;
            $display("FAIL to_high_count: timeouts=%0d valids=%0d, want 1/0", tq.size(), vq_p.size());
        end
        if (tq.size() == 1) begin
            n_chk++;
            if (tq[0] - arm_cyc !== 63) begin
                n_fail++;
                $display("FAIL to_high_delay: gap=%0d, want 63", tq[0] - arm_cyc);
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        wave(5, 5, 2);
        repeat (3) step(1'b1);
        en = 1'b0;
        step(1'b1);
        n_chk++;
        if (no_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop: no_sig=%b, want 1", no_sig);
        end
        step(1'b1);
        en = 1'b1;
        repeat (5) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 2 || no_sig !== 1'b1) begin
            n_fail++;
            $display("FAIL en_discard: valids=%0d no_sig=%b, want 2/1", vq_p.size(), no_sig);
        end
        wave(5, 5, 2);
        repeat (3) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 3) begin
            n_fail++;
            $display("FAIL en_rearm_count: valids=%0d, want 3", vq_p.size());
        end
        if (vq_p.size() == 3) begin
            n_chk++;
            if (vq_p[2] !== 10 || vq_h[2] !== 5 || vq_t[2] - arm_cyc !== 10) begin
                n_fail++;
                $display("FAIL en_rearm_vals: period=%0d high=%0d gap=%0d, want 10/5/10", vq_p[2], vq_h[2], vq_t[2] - arm_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wave(5, 5, 2);
        repeat (3) step(1'b1);
        n_chk++;
        if (valid !== 1'b1 || period !== 10 || high_time !== 5) begin
            n_fail++;
            $display("FAIL rmid_pre: valid=%b period=%0d high=%0d, want 1/10/5", valid, period, high_time);
        end
        rst = 1'b0;
        repeat (2) step(1'b1);
        n_chk++;
        if (period !== 0 || high_time !== 0 || no_sig !== 1'b1 || valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_reset: period=%0d high=%0d no_sig=%b valid=%b to=%b, want 0/0/1/0/0", period, high_time, no_sig, valid, timeout);
        end
        rst = 1'b1;
        repeat (5) step(1'b0);
        clear_q();
        wave(5, 5, 2);
        repeat (3) step(1'b0);
        n_chk++;
        if (vq_p.size() !== 1) begin
            n_fail++;
            $display("FAIL rmid_count: valids=%0d, want 1", vq_p.size());
        end
        if (vq_p.size() == 1) begin
            n_chk++;
            if (vq_p[0] !== 10 || vq_h[0] !== 5 || vq_t[0] - arm_cyc !== 10) begin
                n_fail++;
                $display("FAIL rmid_vals: period=%0d high=%0d gap=%0d, want 10/5/10", vq_p[0], vq_h[0], vq_t[0] - arm_cyc);
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        prev_ns = 1'b1;
        prev_v  = 1'b0;
        rst     = 1'b0;
        en      = 1'b1;
        sig_in  = 1'b0;
        test_reset();
        test_tff();
        test_duty();
        test_min_period();
        test_saturation();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
